tristate_bus_arbiter: RTL and testbench
=======================================

Name: tristate_bus_arbiter

Overview:
- Generates the per-driver Ctrl enables for a shared tri-state bus built from tri_state_buffer instances, one buffer per requester.
- Round-robin arbitration between N requesters.
- Guarantees the enables are one-hot-or-zero, so at most one buffer drives the bus at any time.
- Inserts a configurable all-off turnaround gap between owners so drivers never overlap.

Parameters:
- N, 4, number of requesters / tri-state drivers (N >= 2).
- TURN, 1, turnaround cycles with all enables low between owners (TURN >= 1).
- MAX_HOLD, 8, maximum consecutive enabled cycles for one owner when others are waiting (MAX_HOLD >= 1; only used with PREEMPT_EN).

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Req  input  N  request per driver; level-sensitive, held while the bus is wanted.
- Ctrl_en  output  N  registered enables, one bit to each tri_state_buffer Ctrl; one-hot or all-zero.
- Grant_id  output  clog2(N)  index of current/last owner.
- Bus_busy  output  1  high in GRANT or TURNAROUND.

Behaviour:
- Reset (Rst=1 at an edge): state=IDLE, Ctrl_en=0, Grant_id=0, Bus_busy=0, rr pointer=0, hold_cnt=0, turn_cnt=0. Rst overrides everything, including mid-grant (Ctrl_en drops at that edge, with no turnaround).
- All outputs are registered and derived from state/owner; there is no combinational path from Req to Ctrl_en.
- Arbitration function: winner = first set Req bit searching upward from ptr, wrapping N-1 -> 0. On grant, ptr <= winner+1 mod N.
- IDLE:
  - Ctrl_en=0, Bus_busy=0.
  - If |Req is high at edge k: state=GRANT, owner=winner, hold_cnt=1.
  - Ctrl_en=onehot(owner) and Grant_id=owner are visible after edge k (1-cycle latency).
- GRANT:
  - Ctrl_en=onehot(owner).
  - If Req[owner]=0: go to TURNAROUND.
  - Else if PREEMPT_EN, hold_cnt==MAX_HOLD and any other Req bit is set: go to TURNAROUND (preempt).
  - Otherwise stay; hold_cnt increments, saturating at MAX_HOLD.
  - A lone requester is never preempted.
- TURNAROUND:
  - Ctrl_en=0, Bus_busy=1, turn_cnt counts 1..TURN; Grant_id holds the old owner.
  - At the edge ending cycle TURN: if |Req, go to GRANT with a new winner (same rules as IDLE, no extra IDLE cycle); else go to IDLE.
  - The departing owner is eligible again only via round-robin order.
- Requests raised or dropped during TURNAROUND take effect at the arbitration edge only.
- Invariants:
  - popcount(Ctrl_en) <= 1 every cycle.
  - Between any two different owners, at least TURN cycles with Ctrl_en=0.
  - The same owner re-granted after release also passes through TURNAROUND.
- Grant_id retains the last owner in IDLE. Its value after reset is 0.

Optional Feature:
- Macro PREEMPT_EN.
  - Defined: MAX_HOLD preemption active as described.
  - Undefined: the owner keeps the bus until it drops Req; hold_cnt logic is not generated; MAX_HOLD is ignored.
- Port list is identical in both builds.

Test Plan (N=4, TURN=1, MAX_HOLD=4, PREEMPT_EN defined unless noted):
- Reset: Rst=1 for 2 cycles with Req=4'b1111 -> Ctrl_en=0, Bus_busy=0 during reset. First grant after release is to driver 0 (Ctrl_en=4'b0001) one cycle later.
- Single request: Req=4'b0100 sampled at edge k -> Ctrl_en=4'b0100, Grant_id=2 after edge k. Drop Req -> Ctrl_en=0 for exactly 1 cycle (Bus_busy=1), then IDLE with Bus_busy=0.
- Fairness: Req=4'b1111 held 30 cycles -> Ctrl_en sequence 0001,0010,0100,1000,0001..., each on for exactly 4 cycles with one all-zero cycle between. Checker confirms popcount<=1 every cycle.
- Wrap/skip: owner 2 drops Req while Req=4'b1011 -> after 1 turnaround cycle grant to 3, then on its release grant to 0 (not 1).
- Reset mid-grant: Rst pulsed while Ctrl_en=4'b0100 -> Ctrl_en=0 at that edge, ptr=0. With Req=4'b1111 afterwards, first grant is to driver 0.
- PREEMPT_EN undefined: Req=4'b0011 held 20 cycles -> Ctrl_en=4'b0001 continuously for all 20 cycles, never switching to driver 1.

Source files
------------

// File: rtl/tristate_bus_arbiter_if.sv
// Bundle of the request/enable signals between the arbiter and the tri-state drivers.
interface tristate_bus_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  Req;
    logic [N-1:0]  Ctrl_en;
    logic [IW-1:0] Grant_id;
    logic          Bus_busy;

    modport master (input Req, output Ctrl_en, output Grant_id, output Bus_busy);
    modport slave  (output Req, input Ctrl_en, input Grant_id, input Bus_busy);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin enable generator for a shared tri-state bus with an all-off turnaround gap.
// Macro PREEMPT_EN builds the MAX_HOLD preemption of a long-holding owner.
module tristate_bus_arbiter #(
    parameter int N        = 4,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    tristate_bus_arbiter_if.master bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TURN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t        state_r;
    logic [IW-1:0] ptr_r;
    logic [IW-1:0] owner_r;
    logic [TW-1:0] turn_cnt_r;
    logic [N-1:0]  ctrl_en_r;
    logic          busy_r;

    logic [N-1:0]  req_s;
    logic          req_any_s;
    logic [IW-1:0] win_s;
    logic [IW-1:0] win_next_s;
    logic [N-1:0]  win_onehot_s;
    logic          arb_s;
    logic          release_s;

`ifdef PREEMPT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt_r;
`endif

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] id);
        onehot = {{(N-1){1'b0}}, 1'b1} << id;
    endfunction

    // First requester at or above ptr, wrapping from N-1 back to 0.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] ptr);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = ptr;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                w     = IW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    // Arbitration decode: winner, next pointer, arbitration edge and owner release.
    always_comb begin
        req_s        = bus.Req;
        req_any_s    = |req_s;
        win_s        = rr_pick(req_s, ptr_r);
        win_onehot_s = onehot(win_s);
        if (win_s == IW'(N - 1)) begin
            win_next_s = {IW{1'b0}};
        end else begin
            win_next_s = win_s + IW'(1);
        end
        if (state_r == ST_IDLE) begin
            arb_s = 1'b1;
        end else if ((state_r == ST_TURN) && (turn_cnt_r == TW'(TURN))) begin
            arb_s = 1'b1;
        end else begin
            arb_s = 1'b0;
        end
`ifdef PREEMPT_EN
        if (!req_s[owner_r]) begin
            release_s = 1'b1;
        end else if ((hold_cnt_r == HW'(MAX_HOLD)) && ((req_s & ~onehot(owner_r)) != {N{1'b0}})) begin
            release_s = 1'b1;
        end else begin
            release_s = 1'b0;
        end
`else
        if (!req_s[owner_r]) begin
            release_s = 1'b1;
        end else begin
            release_s = 1'b0;
        end
`endif
    end

    // Arbiter FSM; enables only change here, so Req never reaches Ctrl_en combinationally.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {IW{1'b0}};
            owner_r    <= {IW{1'b0}};
            turn_cnt_r <= {TW{1'b0}};
            ctrl_en_r  <= {N{1'b0}};
            busy_r     <= 1'b0;
`ifdef PREEMPT_EN
            hold_cnt_r <= {HW{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_GRANT: begin
                    if (release_s) begin
                        state_r    <= ST_TURN;
                        ctrl_en_r  <= {N{1'b0}};
                        turn_cnt_r <= TW'(1);
                    end else begin
`ifdef PREEMPT_EN
                        if (hold_cnt_r != HW'(MAX_HOLD)) begin
                            hold_cnt_r <= hold_cnt_r + HW'(1);
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
`else
                        state_r <= ST_GRANT;
`endif
                    end
                end
                ST_IDLE, ST_TURN: begin
                    if (arb_s && req_any_s) begin
                        state_r    <= ST_GRANT;
                        owner_r    <= win_s;
                        ptr_r      <= win_next_s;
                        ctrl_en_r  <= win_onehot_s;
                        busy_r     <= 1'b1;
                        turn_cnt_r <= {TW{1'b0}};
`ifdef PREEMPT_EN
                        hold_cnt_r <= HW'(1);
`endif
                    end else if (arb_s) begin
                        state_r    <= ST_IDLE;
                        ctrl_en_r  <= {N{1'b0}};
                        busy_r     <= 1'b0;
                        turn_cnt_r <= {TW{1'b0}};
                    end else begin
                        turn_cnt_r <= turn_cnt_r + TW'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ctrl_en_r  <= {N{1'b0}};
                    busy_r     <= 1'b0;
                    turn_cnt_r <= {TW{1'b0}};
                end
            endcase
        end
    end

    assign bus.Ctrl_en  = ctrl_en_r;
    assign bus.Grant_id = owner_r;
    assign bus.Bus_busy = busy_r;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench: behavioural owner/gap model compared every cycle, plus literal anchors.
module tb_tristate_bus_arbiter;
    localparam int N    = 4;
    localparam int TURN = 1;
    localparam int MAXH = 4;
`ifdef PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    tristate_bus_arbiter_if #(.N(N)) ifc();

    tristate_bus_arbiter #(.N(N), .TURN(TURN), .MAX_HOLD(MAXH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (ifc)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who drives, how long it has driven, how long the bus has been off since release.
    int         m_id = 0, m_run = 0, m_gap = 0, m_ptr = 0;
    logic [3:0] m_en = 4'b0000;
    logic       m_busy = 1'b0;

    always @(posedge Clk) begin
        logic [3:0] r;
        bit         found;
        r = ifc.Req;
        if (Rst) begin
            m_id = 0; m_run = 0; m_gap = 0; m_ptr = 0;
        end else if (m_run > 0) begin
            if (!r[m_id] || (PREEMPT && m_run >= MAXH && (r & ~(4'b0001 << m_id)) != 4'b0000)) begin
                m_run = 0;
                m_gap = 1;
            end else begin
                m_run++;
            end
        end else if (m_gap > 0 && m_gap < TURN) begin
            m_gap++;
        end else begin
            m_gap = 0;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && r[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    m_id  = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_ptr = (m_id + 1) % N;
                m_run = 1;
            end
        end
        m_en   = (m_run > 0) ? (4'b0001 << m_id) : 4'b0000;
        m_busy = (m_run > 0) || (m_gap > 0);
    end

    // Compare process plus overlap/gap invariants, sampled mid-cycle.
    int         zero_run = 0;
    logic [3:0] last_en = 4'b0000;
    always @(negedge Clk) begin
        chk("ctrl_en", ifc.Ctrl_en, m_en);
        chk("bus_busy", ifc.Bus_busy, m_busy);
        chk("grant_id", ifc.Grant_id, m_id);
        chk("popcount_le1", ($countones(ifc.Ctrl_en) <= 1) ? 1 : 0, 1);
        if (ifc.Ctrl_en != 4'b0000 && last_en != 4'b0000 && ifc.Ctrl_en != last_en)
            chk("no_gap_switch", ifc.Ctrl_en, last_en);
        if (ifc.Ctrl_en != 4'b0000 && last_en == 4'b0000 && !Rst)
            chk("gap_len_ge_turn", (zero_run >= TURN) ? 1 : 0, 1);
        zero_run = (ifc.Ctrl_en == 4'b0000) ? zero_run + 1 : 0;
        last_en  = ifc.Ctrl_en;
    end

    task automatic step(input logic [3:0] r, input logic rs);
        ifc.Req = r;
        Rst     = rs;
        @(posedge Clk);
        #1;
    endtask

    logic [3:0] rq;
    logic [3:0] exp_en;

    initial begin
        ifc.Req = 4'b0000;
        // reset with all requesting, then first grant to 0
        step(4'b1111, 1'b1);
        chk("rst_en", ifc.Ctrl_en, 4'b0000);
        chk("rst_busy", ifc.Bus_busy, 1'b0);
        step(4'b1111, 1'b1);
        chk("rst_id", ifc.Grant_id, 2'd0);
        step(4'b1111, 1'b0);
        chk("first_grant", ifc.Ctrl_en, 4'b0001);
        // single request and release
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b0);
        chk("single_en", ifc.Ctrl_en, 4'b0100);
        chk("single_id", ifc.Grant_id, 2'd2);
        step(4'b0000, 1'b0);
        chk("turn_en", ifc.Ctrl_en, 4'b0000);
        chk("turn_busy", ifc.Bus_busy, 1'b1);
        step(4'b0000, 1'b0);
        chk("idle_busy", ifc.Bus_busy, 1'b0);
        chk("idle_keep_id", ifc.Grant_id, 2'd2);
        // wrap/skip: owner 2 leaves with 1011 pending -> 3, then 0 (not 1)
        step(4'b0100, 1'b0);
        step(4'b1011, 1'b0);
        chk("wrap_turn", ifc.Ctrl_en, 4'b0000);
        step(4'b1011, 1'b0);
        chk("wrap_to3", ifc.Ctrl_en, 4'b1000);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b0);
        chk("wrap_to0", ifc.Ctrl_en, 4'b0001);
        // reset in the middle of a grant
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        chk("mid_pre", ifc.Ctrl_en, 4'b0100);
        step(4'b1111, 1'b1);
        chk("mid_rst_en", ifc.Ctrl_en, 4'b0000);
        chk("mid_rst_busy", ifc.Bus_busy, 1'b0);
        step(4'b1111, 1'b0);
        chk("mid_regrant0", ifc.Ctrl_en, 4'b0001);
        step(4'b1111, 1'b1);
`ifdef PREEMPT_EN
        // fairness: four on, one off, rotating
        for (int i = 0; i < 30; i++) begin
            step(4'b1111, 1'b0);
            exp_en = ((i % 5) < 4) ? (4'b0001 << ((i / 5) % 4)) : 4'b0000;
            chk("fair_seq", ifc.Ctrl_en, exp_en);
        end
`else
        // no preemption: owner 0 keeps the bus
        for (int i = 0; i < 20; i++) begin
            step(4'b0011, 1'b0);
            chk("hold_no_preempt", ifc.Ctrl_en, 4'b0001);
        end
`endif
        // random traffic with occasional resets
        rq = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            step(rq, ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        @(negedge Clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
